// File: rtl/echo_ind_arbiter.sv
// Round-robin arbiter that shares one echo indication channel among NREQ
// requesters. The winner is captured into a single-entry output register.
// The register can be refilled in the same cycle that it drains, so the
// channel sustains one indication per cycle.

// Handshake for one requester. It turns the shared grant into this lane's
// RDY bit and classifies the lane's ENA as a fire or as a protocol error.
module echo_ind_lane (
  input  logic grant_i,   // this lane is the arbitration winner
  input  logic open_i,    // the output slot can take a payload this cycle
  input  logic ena_i,
  output logic rdy_o,
  output logic fire_o,
  output logic err_o
);
  assign rdy_o  = grant_i & open_i;
  assign fire_o = ena_i & rdy_o;
  assign err_o  = ena_i & ~rdy_o;
endmodule

module echo_ind_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_want,
  output logic [NREQ-1:0]       req__RDY,
  input  logic [NREQ-1:0]       req__ENA,
  input  logic [NREQ*WIDTH-1:0] req_v,
  input  logic                  ind_echo__RDY,
  output logic                  ind_echo__ENA,
  output logic [WIDTH-1:0]      ind_echo_v,
  output logic [IDW-1:0]        last_grant,
  output logic                  proto_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   last_q, last_d;
  logic             perr_q, perr_d;

  logic             slot_free, open;
  logic             found;
  logic [IDW-1:0]   win_idx;
  logic [NREQ-1:0]  lane_grant, lane_fire, lane_err;
  logic             accepted;
  logic [WIDTH-1:0] win_pay;

  // Replacement in the same cycle is allowed when downstream takes the held entry.
  // RDY is forced low during reset so that no requester sees a grant.
  assign slot_free = (state_q == EMPTY) | ind_echo__RDY;
  assign open      = slot_free & ~RST;

  // Rotating priority search that starts at rr_ptr and wraps NREQ-1 -> 0.
  always_comb begin
    logic [IDW-1:0] idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_want[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane_grant[gi] = found & (win_idx == IDW'(gi));
      echo_ind_lane u_lane (
        .grant_i (lane_grant[gi]),
        .open_i  (open),
        .ena_i   (req__ENA[gi]),
        .rdy_o   (req__RDY[gi]),
        .fire_o  (lane_fire[gi]),
        .err_o   (lane_err[gi])
      );
    end
  endgenerate

  assign accepted = |lane_fire;

  // Winner payload mux. The grant is one-hot, so an OR of the gated slices is exact.
  always_comb begin
    win_pay = '0;
    for (int i = 0; i < NREQ; i++)
      if (lane_grant[i]) win_pay = win_pay | req_v[i*WIDTH +: WIDTH];
  end

  // Next state for the slot and the fairness state. Only an accept moves the pointer.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    last_d   = last_q;
    perr_d   = perr_q | (|lane_err);
    if (accepted) begin
      state_d  = FULL;
      data_d   = win_pay;
      last_d   = win_idx;
      rr_ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end else if (state_q == FULL && ind_echo__RDY) begin
      state_d  = EMPTY;
    end
  end

  // State registers. Reset discards any held payload.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      rr_ptr_q <= '0;
      last_q   <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
      last_q   <= last_d;
      perr_q   <= perr_d;
    end
  end

  assign ind_echo__ENA = (state_q == FULL);
  assign ind_echo_v    = data_q;
  assign last_grant    = last_q;
  assign proto_err     = perr_q;

endmodule

// File: tb/tb_echo_ind_arbiter.sv
// Directed tests for echo_ind_arbiter with NREQ=4, WIDTH=32 and IDW=2.
// Inputs change 1 time unit after posedge. Registered outputs are sampled at
// posedge+1. Combinational RDY is sampled at posedge+2.
module tb_echo_ind_arbiter;
  localparam int NREQ = 4, WIDTH = 32, IDW = 2;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NREQ-1:0]       req_want, req__RDY, req__ENA;
  logic [NREQ*WIDTH-1:0] req_v;
  logic                  ind_echo__RDY, ind_echo__ENA, proto_err;
  logic [WIDTH-1:0]      ind_echo_v;
  logic [IDW-1:0]        last_grant;

  int n_vec = 0;
  int n_err = 0;

  echo_ind_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST), .req_want(req_want), .req__RDY(req__RDY),
    .req__ENA(req__ENA), .req_v(req_v), .ind_echo__RDY(ind_echo__RDY),
    .ind_echo__ENA(ind_echo__ENA), .ind_echo_v(ind_echo_v),
    .last_grant(last_grant), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; req_want = 4'b1111; req__ENA = '0; req_v = '0; ind_echo__RDY = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      n_vec++; if (ind_echo__ENA !== 1'b0) begin n_err++; $display("FAIL rst_ena got=%b exp=0", ind_echo__ENA); end
      n_vec++; if (req__RDY !== 4'b0000) begin n_err++; $display("FAIL rst_rdy got=%b exp=0000", req__RDY); end
      n_vec++; if (last_grant !== 2'd0) begin n_err++; $display("FAIL rst_last got=%0d exp=0", last_grant); end
      n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rst_perr got=%b exp=0", proto_err); end
      n_vec++; if (ind_echo_v !== 32'h0) begin n_err++; $display("FAIL rst_v got=%h exp=0", ind_echo_v); end
    end
    RST = 1'b0; req_want = '0;
  endtask

  task automatic test_round_robin();
    int g;
    for (int i = 0; i < NREQ; i++) req_v[i*WIDTH +: WIDTH] = 32'hA0 + i;
    req_want = 4'b1111; ind_echo__RDY = 1'b1;
    for (int s = 0; s < 5; s++) begin
      g = s % 4;
      req__ENA = 4'(1 << g); #1;
      n_vec++; if (req__RDY !== 4'(1 << g)) begin n_err++; $display("FAIL rr_rdy%0d got=%b exp=%b", s, req__RDY, 4'(1 << g)); end
      tick();
      req__ENA = '0;
      n_vec++; if (ind_echo__ENA !== 1'b1) begin n_err++; $display("FAIL rr_ena%0d got=%b exp=1", s, ind_echo__ENA); end
      n_vec++; if (ind_echo_v !== 32'hA0 + 32'(g)) begin n_err++; $display("FAIL rr_v%0d got=%h exp=%h", s, ind_echo_v, 32'hA0 + 32'(g)); end
      n_vec++; if (last_grant !== 2'(g)) begin n_err++; $display("FAIL rr_last%0d got=%0d exp=%0d", s, last_grant, g); end
    end
    req_want = '0; tick();
    n_vec++; if (ind_echo__ENA !== 1'b0) begin n_err++; $display("FAIL rr_drain got=%b exp=0", ind_echo__ENA); end
  endtask

  // The pointer is at 1 on entry.
  task automatic test_backpressure();
    req_v[1*WIDTH +: WIDTH] = 32'h55; req_want = 4'b0010; req__ENA = 4'b0010; ind_echo__RDY = 1'b0; #1;
    n_vec++; if (req__RDY !== 4'b0010) begin n_err++; $display("FAIL bp_rdy_empty got=%b exp=0010", req__RDY); end
    tick();
    req__ENA = '0; req_want = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (req__RDY !== 4'b0000) begin n_err++; $display("FAIL bp_rdy%0d got=%b exp=0000", c, req__RDY); end
      n_vec++; if (ind_echo__ENA !== 1'b1 || ind_echo_v !== 32'h55) begin n_err++; $display("FAIL bp_hold%0d got=%b/%h exp=1/55", c, ind_echo__ENA, ind_echo_v); end
      tick();
    end
    ind_echo__RDY = 1'b1; req_v[2*WIDTH +: WIDTH] = 32'h66; req__ENA = 4'b0100; #1;
    n_vec++; if (req__RDY !== 4'b0100) begin n_err++; $display("FAIL bp_regrant got=%b exp=0100", req__RDY); end
    tick();
    req__ENA = '0; req_want = '0;
    n_vec++; if (ind_echo_v !== 32'h66 || last_grant !== 2'd2) begin n_err++; $display("FAIL bp_next got=%h/%0d exp=66/2", ind_echo_v, last_grant); end
    tick();
  endtask

  // The pointer is at 3 on entry.
  task automatic test_skip_wrap();
    logic [3:0] want_t [5] = '{4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b1000};
    logic [3:0] rdy_t  [5] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b1000};
    int         idx_t  [5] = '{0, 2, 0, 2, 3};
    for (int i = 0; i < NREQ; i++) req_v[i*WIDTH +: WIDTH] = 32'hB0 + i;
    ind_echo__RDY = 1'b1;
    for (int s = 0; s < 5; s++) begin
      req_want = want_t[s]; req__ENA = rdy_t[s]; #1;
      n_vec++; if (req__RDY !== rdy_t[s]) begin n_err++; $display("FAIL sw_rdy%0d got=%b exp=%b", s, req__RDY, rdy_t[s]); end
      tick();
      n_vec++; if (last_grant !== 2'(idx_t[s]) || ind_echo_v !== 32'hB0 + 32'(idx_t[s])) begin n_err++; $display("FAIL sw_cap%0d got=%0d/%h exp=%0d/%h", s, last_grant, ind_echo_v, idx_t[s], 32'hB0 + 32'(idx_t[s])); end
    end
    req__ENA = '0; req_want = 4'b1111; #1;
    n_vec++; if (req__RDY !== 4'b0001) begin n_err++; $display("FAIL sw_wrap got=%b exp=0001", req__RDY); end
    req_want = '0; tick();
  endtask

  // The pointer is at 0 on entry and the slot is empty.
  task automatic test_proto_err();
    req_want = 4'b0001; req__ENA = 4'b0010; ind_echo__RDY = 1'b1; #1;
    n_vec++; if (req__RDY !== 4'b0001 || proto_err !== 1'b0) begin n_err++; $display("FAIL pe_pre got=%b/%b exp=0001/0", req__RDY, proto_err); end
    tick();
    req__ENA = '0; req_want = '0;
    n_vec++; if (ind_echo__ENA !== 1'b0 || last_grant !== 2'd3) begin n_err++; $display("FAIL pe_nocap got=%b/%0d exp=0/3", ind_echo__ENA, last_grant); end
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL pe_set got=%b exp=1", proto_err); end
    tick(); tick();
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL pe_sticky got=%b exp=1", proto_err); end
    RST = 1'b1; tick(); RST = 1'b0;
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL pe_clear got=%b exp=0", proto_err); end
  endtask

  task automatic test_reset_mid();
    req_v[0 +: WIDTH] = 32'h77; req_want = 4'b0001; req__ENA = 4'b0001; ind_echo__RDY = 1'b0;
    tick();
    req__ENA = '0; req_want = '0;
    n_vec++; if (ind_echo__ENA !== 1'b1 || ind_echo_v !== 32'h77) begin n_err++; $display("FAIL rm_full got=%b/%h exp=1/77", ind_echo__ENA, ind_echo_v); end
    tick();
    RST = 1'b1; tick(); RST = 1'b0;
    n_vec++; if (ind_echo__ENA !== 1'b0 || ind_echo_v !== 32'h0) begin n_err++; $display("FAIL rm_rst got=%b/%h exp=0/0", ind_echo__ENA, ind_echo_v); end
    ind_echo__RDY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (ind_echo__ENA !== 1'b0) begin n_err++; $display("FAIL rm_resend%0d got=%b exp=0", c, ind_echo__ENA); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_proto_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
